// File: rtl/shake128_squeeze.sv
// SHAKE128 squeeze engine.
//
// Loads an absorbed, permuted Keccak state and streams OUT_LANES 64-bit lanes
// out of the rate portion, one lane per accepted beat. When the squeeze runs
// past the 21-lane rate, it asks an external Keccak-f[1600] block for another
// permutation and resumes from lane 0 of the new state.
//
// Parameters:
//   OUT_LANES  - 64-bit lanes produced per squeeze (1..255)
//   RATE_LANES - SHAKE128 rate in lanes (21); not meant to be overridden
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   state_in, state_valid   - new state to squeeze (accepted in idle), also
//                             the permuted state returned with perm_done
//   state_ready             - idle, able to accept state_in
//   out_data, out_valid,
//   out_ready, out_last     - output lane stream (valid/ready handshake)
//   perm_req, state_out     - permutation request and state to permute
//   perm_done               - permuted state is present on state_in
//   done                    - one-cycle pulse after the final beat transfers
//   blocks_squeezed         - permutations consumed in this squeeze
//                             (only with SHAKE128_SQUEEZE_STATUS_EN defined)
module shake128_squeeze #(
  parameter int unsigned OUT_LANES  = 4,
  parameter int unsigned RATE_LANES = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1599:0] state_in,
  input  logic          state_valid,
  output logic          state_ready,
  output logic [63:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          perm_req,
  output logic [1599:0] state_out,
  input  logic          perm_done,
`ifdef SHAKE128_SQUEEZE_STATUS_EN
  output logic          done,
  output logic [7:0]    blocks_squeezed
`else
  output logic          done
`endif
);

  localparam int unsigned IdxW = $clog2(RATE_LANES);
  localparam logic [IdxW-1:0] LastLane = IdxW'(RATE_LANES - 1);
  localparam logic [7:0] OutLanes = 8'(OUT_LANES);

  typedef enum logic [1:0] {StIdle, StEmit, StPerm} fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [1599:0]   st_q, st_d;
  logic [IdxW-1:0] lane_idx_q, lane_idx_d;
  logic [7:0]      remaining_q, remaining_d;
  logic            done_q, done_d;
  logic [IdxW+5:0] lane_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      st_q        <= '0;
      lane_idx_q  <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      lane_idx_q  <= lane_idx_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    lane_idx_d  = lane_idx_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (fsm_q)
      StIdle: begin
        if (state_valid) begin
          st_d        = state_in;
          lane_idx_d  = '0;
          remaining_d = OutLanes;
          fsm_d       = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          remaining_d = remaining_q - 8'd1;
          lane_idx_d  = (lane_idx_q == LastLane) ? '0 : lane_idx_q + 1'b1;
          if (remaining_q == 8'd1) begin
            fsm_d  = StIdle;
            done_d = 1'b1;
          end else if (lane_idx_q == LastLane) begin
            // Rate exhausted with lanes still owed: need a fresh permutation.
            fsm_d = StPerm;
          end
        end
      end
      StPerm: begin
        if (perm_done) begin
          st_d       = state_in;
          lane_idx_d = '0;
          fsm_d      = StEmit;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // Lane i occupies bits [i*64 +: 64]; the index never exceeds RATE_LANES-1.
  assign lane_base   = {lane_idx_q, 6'd0};
  assign state_ready = (fsm_q == StIdle);
  assign out_valid   = (fsm_q == StEmit);
  assign out_last    = out_valid && (remaining_q == 8'd1);
  assign out_data    = out_valid ? st_q[lane_base +: 64] : 64'd0;
  assign perm_req    = (fsm_q == StPerm);
  assign state_out   = st_q;
  assign done        = done_q;

`ifdef SHAKE128_SQUEEZE_STATUS_EN
  logic [7:0] blocks_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_q <= 8'd0;
    end else if ((fsm_q == StIdle) && state_valid) begin
      blocks_q <= 8'd0;
    end else if ((fsm_q == StPerm) && perm_done && (blocks_q != 8'hFF)) begin
      blocks_q <= blocks_q + 8'd1;
    end
  end

  assign blocks_squeezed = blocks_q;
`endif

endmodule

// File: tb/tb_shake128_squeeze.sv
// Directed bench for shake128_squeeze: a 4-lane instance plus 21- and
// 22-lane instances sharing one input set (the rate boundary cases).
module tb_shake128_squeeze;

  logic clk;
  logic rst_n;

  // 4-lane instance
  logic [1599:0] si4;
  logic          sv4, or4, pd4;
  logic          sr4, ov4, ol4, pr4, dn4;
  logic [63:0]   od4;
  logic [1599:0] so4;

  // 21- and 22-lane instances, shared inputs
  logic [1599:0] sil;
  logic          svl, orl, pdl;
  logic          sr21, ov21, ol21, pr21, dn21;
  logic [63:0]   od21;
  logic [1599:0] so21;
  logic          sr22, ov22, ol22, pr22, dn22;
  logic [63:0]   od22;
  logic [1599:0] so22;

`ifdef SHAKE128_SQUEEZE_STATUS_EN
  logic [7:0] bs4, bs21, bs22;
`endif

  int n_cmp;
  int n_err;

  shake128_squeeze #(.OUT_LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .state_in(si4), .state_valid(sv4), .state_ready(sr4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4), .out_last(ol4), .perm_req(pr4),
    .state_out(so4), .perm_done(pd4),
`ifdef SHAKE128_SQUEEZE_STATUS_EN
    .blocks_squeezed(bs4),
`endif
    .done(dn4)
  );

  shake128_squeeze #(.OUT_LANES(21)) dut21 (
    .clk(clk), .rst_n(rst_n), .state_in(sil), .state_valid(svl), .state_ready(sr21),
    .out_data(od21), .out_valid(ov21), .out_ready(orl), .out_last(ol21), .perm_req(pr21),
    .state_out(so21), .perm_done(pdl),
`ifdef SHAKE128_SQUEEZE_STATUS_EN
    .blocks_squeezed(bs21),
`endif
    .done(dn21)
  );

  shake128_squeeze #(.OUT_LANES(22)) dut22 (
    .clk(clk), .rst_n(rst_n), .state_in(sil), .state_valid(svl), .state_ready(sr22),
    .out_data(od22), .out_valid(ov22), .out_ready(orl), .out_last(ol22), .perm_req(pr22),
    .state_out(so22), .perm_done(pdl),
`ifdef SHAKE128_SQUEEZE_STATUS_EN
    .blocks_squeezed(bs22),
`endif
    .done(dn22)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1599:0] pat(input logic [63:0] base);
    logic [1599:0] p;
    for (int i = 0; i < 25; i++) p[i*64 +: 64] = base + 64'(i);
    return p;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ov4, ol4, pr4, dn4, od4} !== 68'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {ov4, ol4, pr4, dn4, od4});
    end
    n_cmp++;
    if (so4 !== 1600'd0) begin
      n_err++;
      $display("FAIL reset_state_out: got nonzero want 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sr4, sr21, sr22, ov4, ov22, pr22} !== 6'b111000) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 111000", {sr4, sr21, sr22, ov4, ov22, pr22});
    end
`ifdef SHAKE128_SQUEEZE_STATUS_EN
    n_cmp++;
    if (bs22 !== 8'd0) begin
      n_err++;
      $display("FAIL reset_blocks: got %0d want 0", bs22);
    end
`endif
  endtask

  task automatic test_stream;
    si4 = pat(64'h1000); sv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    sv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({ov4, ol4, pr4, dn4, od4} !== {1'b1, (i == 3), 1'b0, 1'b0, 64'h1000 + 64'(i)}) begin
        n_err++;
        $display("FAIL stream_beat%0d: got %h want %h", i, {ov4, ol4, pr4, dn4, od4},
                 {1'b1, (i == 3), 1'b0, 1'b0, 64'h1000 + 64'(i)});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({dn4, ov4, sr4, pr4} !== 4'b1010) begin
      n_err++;
      $display("FAIL stream_done: got %b want 1010", {dn4, ov4, sr4, pr4});
    end
    @(negedge clk);
    n_cmp++;
    if (dn4 !== 1'b0) begin
      n_err++;
      $display("FAIL stream_done_pulse: got %b want 0", dn4);
    end
  endtask

  task automatic test_backpressure;
    si4 = pat(64'h1000); sv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    sv4 = 1'b0;
    n_cmp++;
    if ({ov4, od4} !== {1'b1, 64'h1000}) begin
      n_err++;
      $display("FAIL bp_beat0: got %h want %h", {ov4, od4}, {1'b1, 64'h1000});
    end
    @(negedge clk);
    or4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({ov4, ol4, od4} !== {2'b10, 64'h1001}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %h want %h", k, {ov4, ol4, od4}, {2'b10, 64'h1001});
      end
      @(negedge clk);
    end
    or4 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if ({ov4, ol4, od4} !== {1'b1, (i == 3), 64'h1000 + 64'(i)}) begin
        n_err++;
        $display("FAIL bp_beat%0d: got %h want %h", i, {ov4, ol4, od4},
                 {1'b1, (i == 3), 64'h1000 + 64'(i)});
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({dn4, ov4} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_done: got %b want 10", {dn4, ov4});
    end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    pd4 = 1'b1;
    @(negedge clk);
    pd4 = 1'b0;
    n_cmp++;
    if ({sr4, ov4, pr4, dn4} !== 4'b1000) begin
      n_err++;
      $display("FAIL ignore_perm_done_idle: got %b want 1000", {sr4, ov4, pr4, dn4});
    end
    si4 = pat(64'h1000); sv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    sv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        si4 = pat(64'h2000);
        sv4 = 1'b1;
      end else begin
        sv4 = 1'b0;
      end
      n_cmp++;
      if ({ov4, ol4, sr4, od4} !== {1'b1, (i == 3), 1'b0, 64'h1000 + 64'(i)}) begin
        n_err++;
        $display("FAIL ignore_beat%0d: got %h want %h", i, {ov4, ol4, sr4, od4},
                 {1'b1, (i == 3), 1'b0, 64'h1000 + 64'(i)});
      end
      @(negedge clk);
    end
    sv4 = 1'b0;
    n_cmp++;
    if (dn4 !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_done: got %b want 1", dn4);
    end
    @(negedge clk);
  endtask

  task automatic test_perm;
    logic [1599:0] loaded;
    logic [1599:0] permuted;
    loaded = pat(64'h1000);
    permuted = loaded;
    permuted[63:0] = 64'hAA;
    sil = loaded; svl = 1'b1; orl = 1'b1;
    @(negedge clk);
    svl = 1'b0;
    for (int i = 0; i < 21; i++) begin
      n_cmp++;
      if ({ov22, ol22, pr22, od22} !== {3'b100, 64'h1000 + 64'(i)}) begin
        n_err++;
        $display("FAIL perm22_beat%0d: got %h want %h", i, {ov22, ol22, pr22, od22},
                 {3'b100, 64'h1000 + 64'(i)});
      end
      n_cmp++;
      if ({ov21, ol21, pr21, od21} !== {1'b1, (i == 20), 1'b0, 64'h1000 + 64'(i)}) begin
        n_err++;
        $display("FAIL perm21_beat%0d: got %h want %h", i, {ov21, ol21, pr21, od21},
                 {1'b1, (i == 20), 1'b0, 64'h1000 + 64'(i)});
      end
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      n_cmp++;
      if ({ov22, pr22, dn22, (so22 === loaded)} !== 4'b0101) begin
        n_err++;
        $display("FAIL perm22_req%0d: got %b want 0101", c, {ov22, pr22, dn22, (so22 === loaded)});
      end
      n_cmp++;
      if ({dn21, pr21, ov21} !== {(c == 0), 2'b00}) begin
        n_err++;
        $display("FAIL perm21_end%0d: got %b want %b", c, {dn21, pr21, ov21}, {(c == 0), 2'b00});
      end
      if (c == 1) begin
        sil = permuted;
        pdl = 1'b1;
      end
      @(negedge clk);
    end
    pdl = 1'b0;
    n_cmp++;
    if ({ov22, ol22, pr22, od22} !== {3'b110, 64'hAA}) begin
      n_err++;
      $display("FAIL perm22_last: got %h want %h", {ov22, ol22, pr22, od22}, {3'b110, 64'hAA});
    end
    n_cmp++;
    if ({sr21, ov21, pr21} !== 3'b100) begin
      n_err++;
      $display("FAIL perm21_ignore_done: got %b want 100", {sr21, ov21, pr21});
    end
`ifdef SHAKE128_SQUEEZE_STATUS_EN
    n_cmp++;
    if ({bs22, bs21} !== {8'd1, 8'd0}) begin
      n_err++;
      $display("FAIL perm_blocks: got %h want 0100", {bs22, bs21});
    end
`endif
    @(negedge clk);
    n_cmp++;
    if ({dn22, ov22, pr22, sr22} !== 4'b1001) begin
      n_err++;
      $display("FAIL perm22_done: got %b want 1001", {dn22, ov22, pr22, sr22});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    si4 = pat(64'h1000); sv4 = 1'b1; or4 = 1'b1;
    @(negedge clk);
    sv4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ov4, od4} !== {1'b1, 64'h1002}) begin
      n_err++;
      $display("FAIL rstmid_beat2: got %h want %h", {ov4, od4}, {1'b1, 64'h1002});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov4, ol4, pr4, dn4, od4, (so4 === 1600'd0)} !== {68'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %h want 1", {ov4, ol4, pr4, dn4, od4, (so4 === 1600'd0)});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({sr4, ov4, dn4, pr4} !== 4'b1000) begin
        n_err++;
        $display("FAIL rstmid_after%0d: got %b want 1000", k, {sr4, ov4, dn4, pr4});
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    si4 = '0; sv4 = 1'b0; or4 = 1'b0; pd4 = 1'b0;
    sil = '0; svl = 1'b0; orl = 1'b0; pdl = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_ignore();
    test_perm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
